memshare_regfile_loader: RTL and testbench
==========================================

MEMSHARE_REGFILE_LOADER -- requirements
Module: memshare_regfile_loader

Interface
REQ-001 SHALL have parameter PAGE_NUM, default 32, the number of memShare regFile pages.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, the page address width.
REQ-003 SHALL have parameter PAGE_WIDTH, default 7, the Type-0 page word: {pattern[2:0], delta[2:0], isGtr}.
REQ-004 SHALL have parameter SHARE_GROUP_SIZE, default 5, the legal upper bound (exclusive) for pattern and delta.
REQ-005 SHALL have port sys_clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port load_start, input, 1 bit: one-cycle request that opens a load session.
REQ-008 SHALL have port base_addr, input, ADDR_WIDTH bits: first page address, sampled with load_start.
REQ-009 SHALL have port page_cnt, input, ADDR_WIDTH+1 bits: number of records in the session (0..PAGE_NUM), sampled with load_start.
REQ-010 SHALL have port rec_valid, input, 1 bit: upstream record valid.
REQ-011 SHALL have port rec_data, input, PAGE_WIDTH bits: upstream record.
REQ-012 SHALL have port rec_ready, output, 1 bit: loader can accept a record.
REQ-013 SHALL have port abort, input, 1 bit: terminates the session.
REQ-014 SHALL have port wr_en, output, 1 bit: regFile write strobe.
REQ-015 SHALL have port wr_addr, output, ADDR_WIDTH bits: regFile write page.
REQ-016 SHALL have port wr_data, output, PAGE_WIDTH bits: regFile write word.
REQ-017 SHALL have port busy, output, 1 bit: session in progress.
REQ-018 SHALL have port done, output, 1 bit: one-cycle session-complete pulse.
REQ-019 SHALL have port err, output, 1 bit: sticky illegal-record flag.

Function
REQ-020 SHALL implement the FSM states IDLE, LOAD and DONE.
REQ-021 In IDLE, load_start with page_cnt>0 SHALL latch base_addr into the address pointer and page_cnt into the remaining counter, clear err, and go to LOAD.
REQ-022 In IDLE, load_start with page_cnt=0 SHALL go to DONE without any write.
REQ-023 rec_ready SHALL be 1 only in LOAD; a record is accepted when rec_valid and rec_ready are both 1.
REQ-024 An accepted record SHALL produce wr_en=1 in the next cycle, with wr_addr equal to the pointer value at acceptance and wr_data equal to rec_data.
REQ-025 Each acceptance SHALL increment the pointer modulo 2^ADDR_WIDTH (31 wraps to 0) and decrement the remaining counter.
REQ-026 A record with pattern>=SHARE_GROUP_SIZE or delta>=SHARE_GROUP_SIZE SHALL NOT be written: it is counted and advances the pointer, and it sets err.
REQ-027 Acceptance of the last record (remaining count=1) SHALL move the FSM to DONE and drop rec_ready in the following cycle.
REQ-028 DONE SHALL last exactly one cycle with done=1, coinciding with the last write's wr_en, then return to IDLE.
REQ-029 busy SHALL be 1 in LOAD and DONE and 0 in IDLE.
REQ-030 load_start while in LOAD or DONE SHALL be ignored.
REQ-031 abort in LOAD SHALL go to IDLE next cycle with no done pulse; a write for a record accepted in the abort cycle SHALL still issue.
REQ-032 If abort and an acceptance coincide, abort SHALL take precedence for state, and the write SHALL still issue.
REQ-033 err SHALL be sticky until the next accepted load_start or reset.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 rst SHALL force IDLE, pointer=0, remaining=0, wr_en=0, wr_addr=0, wr_data=0, rec_ready=0, busy=0, done=0 and err=0, including mid-session.
REQ-036 A write pending at the time of rst SHALL be dropped.

Verification
REQ-037 Start with base=3, cnt=4, and rec_valid held high with legal records -> writes at addresses 3,4,5,6 on consecutive cycles, each 1 cycle after acceptance, and done together with the address-6 write.
REQ-038 Start with base=30, cnt=4 -> write addresses 30,31,0,1.
REQ-039 Second record with pattern=6 -> no write at base+1, err=1, later records at base+2.., done still pulses, and err clears on the next load_start.
REQ-040 Start with cnt=0 -> no wr_en, done 1 cycle after load_start, busy high for exactly that cycle.
REQ-041 abort after 2 acceptances -> 2 writes, no done, IDLE, and rec_ready=0.
REQ-042 rst asserted in the cycle after an acceptance -> no wr_en in the following cycle and all outputs at reset values.

Source files
------------

// File: rtl/memshare_regfile_loader.sv
// memshare_regfile_loader
// Loads a session of Type-0 page words into the memShare regFile.
// A session is opened by load_start (with base_addr/page_cnt), records arrive
// on a valid/ready handshake, and each legal record becomes one regFile write
// one cycle after acceptance. Illegal records still consume an address and a
// count, but are not written and set the sticky err flag.
//
// Ports
//   sys_clk     : clock, rising edge
//   rst         : synchronous active-high reset
//   load_start  : one-cycle session request (sampled in IDLE only)
//   base_addr   : first page address of the session
//   page_cnt    : records in the session, 0..PAGE_NUM
//   rec_valid   : upstream record valid
//   rec_data    : upstream record {pattern[2:0], delta[2:0], isGtr}
//   rec_ready   : loader accepts a record this cycle
//   abort       : ends a running session without a done pulse
//   wr_en       : regFile write strobe
//   wr_addr     : regFile write page
//   wr_data     : regFile write word
//   busy        : session in progress (LOAD or DONE)
//   done        : one-cycle session-complete pulse
//   err         : sticky illegal-record flag
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for load_start
// LOAD  | accepting records, rec_ready high
// DONE  | single cycle, done high (coincides with the last write)
module memshare_regfile_loader #(
  parameter int PAGE_NUM         = 32,
  parameter int ADDR_WIDTH       = 5,
  parameter int PAGE_WIDTH       = 7,
  parameter int SHARE_GROUP_SIZE = 5
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   page_cnt,
  input  logic                  rec_valid,
  input  logic [PAGE_WIDTH-1:0] rec_data,
  output logic                  rec_ready,
  input  logic                  abort,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [PAGE_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] PAGE_NUM_W = (ADDR_WIDTH+1)'(PAGE_NUM);
  localparam logic [ADDR_WIDTH:0] REM_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [3:0]          GROUP_LIM  = 4'(SHARE_GROUP_SIZE);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [PAGE_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rec_ready_q, rec_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [2:0]            rec_pattern;
  logic [2:0]            rec_delta;
  logic                  rec_legal;
  logic                  accept;
  logic [ADDR_WIDTH:0]   cnt_eff;

  assign rec_pattern = rec_data[PAGE_WIDTH-1 -: 3];
  assign rec_delta   = rec_data[PAGE_WIDTH-4 -: 3];
  assign rec_legal   = ({1'b0, rec_pattern} < GROUP_LIM) && ({1'b0, rec_delta} < GROUP_LIM);
  assign accept      = (state_q == ST_LOAD) && rec_valid && rec_ready_q;

  // Oversized counts are clamped so a session never laps the page space.
  assign cnt_eff = (page_cnt > PAGE_NUM_W) ? PAGE_NUM_W : page_cnt;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          err_d = 1'b0;
          if (cnt_eff != '0) begin
            ptr_d   = base_addr;
            rem_d   = cnt_eff;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
          rem_d = rem_q - REM_ONE;
          if (rec_legal) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = rec_data;
          end else begin
            err_d = 1'b1;
          end
          if (rem_q == REM_ONE) begin
            state_d = ST_DONE;
          end
        end
        // Abort wins over a coinciding last acceptance; its write still goes out.
        if (abort) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state.
    rec_ready_d = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rec_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rec_ready_q <= rec_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rec_ready = rec_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_memshare_regfile_loader.sv
// Testbench for memshare_regfile_loader: a session-level reference model
// predicts every output each cycle, a table of directed sessions checks
// aggregate results, and hand sequences pin down exact cycle timing and reset.
module tb_memshare_regfile_loader;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0;
  logic [4:0] base_addr = '0;
  logic [5:0] page_cnt = '0;
  logic       rec_valid = 1'b0;
  logic [6:0] rec_data = '0;
  logic       abort = 1'b0;
  logic       rec_ready;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [6:0] wr_data;
  logic       busy;
  logic       done;
  logic       err;

  memshare_regfile_loader dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .load_start(load_start),
    .base_addr (base_addr),
    .page_cnt  (page_cnt),
    .rec_valid (rec_valid),
    .rec_data  (rec_data),
    .rec_ready (rec_ready),
    .abort     (abort),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: a session is "active" while records may still be taken,
  // "m_done" marks the single completion cycle.
  bit         m_active = 1'b0;
  bit         m_done = 1'b0;
  bit         m_err = 1'b0;
  bit         e_wr_en = 1'b0;
  int         m_left = 0;
  int         m_ptr = 0;
  logic [4:0] e_addr = '0;
  logic [6:0] e_data = '0;

  function automatic bit legal(input logic [6:0] d);
    return (d[6:4] < 3'd5) && (d[3:1] < 3'd5);
  endfunction

  function automatic logic [6:0] good_rec(input int n);
    logic [2:0] p, dl;
    p  = 3'(n % 5);
    dl = 3'((n + 2) % 5);
    return {p, dl, 1'(n % 2)};
  endfunction

  always @(posedge sys_clk) begin : model
    bit acc;
    if (rst) begin
      m_active = 0; m_done = 0; m_err = 0; e_wr_en = 0;
      m_left = 0; m_ptr = 0;
    end else begin
      acc = m_active && rec_valid;
      e_wr_en = acc && legal(rec_data);
      if (e_wr_en) begin
        e_addr = 5'(m_ptr);
        e_data = rec_data;
      end
      if (m_done) begin
        m_done = 0;
      end else if (m_active) begin
        if (acc) begin
          m_ptr = (m_ptr + 1) % 32;
          m_left = m_left - 1;
          if (!legal(rec_data)) m_err = 1;
        end
        if (abort) m_active = 0;
        else if (acc && m_left == 0) begin
          m_active = 0;
          m_done = 1;
        end
      end else if (load_start) begin
        m_err = 0;
        if (page_cnt > 0) begin
          m_active = 1;
          m_ptr = int'(base_addr);
          m_left = int'(page_cnt);
        end else begin
          m_done = 1;
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  int wr_total = 0;
  int done_total = 0;
  logic [4:0] last_wr_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic sample();
    @(negedge sys_clk);
    if (chk_on) begin
      chk("m_rec_ready", rec_ready, m_active);
      chk("m_busy", busy, m_active || m_done);
      chk("m_done", done, m_done);
      chk("m_wr_en", wr_en, e_wr_en);
      chk("m_err", err, m_err);
      if (e_wr_en) begin
        chk("m_wr_addr", wr_addr, e_addr);
        chk("m_wr_data", wr_data, e_data);
      end
    end
    if (wr_en === 1'b1) begin
      wr_total++;
      last_wr_addr = wr_addr;
    end
    if (done === 1'b1) done_total++;
  endtask

  task automatic tick();
    sample();
    #1;
  endtask

  typedef struct {
    logic [4:0] base;
    logic [5:0] cnt;
    int         bad_idx;
    int         abort_at;
    int         exp_nwr;
    logic [4:0] exp_last;
    int         exp_done;
    logic       exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int w0, d0, n, cyc;
    w0 = wr_total; d0 = done_total; n = 0; cyc = 0;
    load_start = 1; base_addr = v.base; page_cnt = v.cnt; rec_valid = 0; abort = 0;
    tick();
    load_start = 0;
    while (cyc < 80 && (m_active || m_done)) begin
      abort = 0; rec_valid = 0;
      if (m_active) begin
        if (n == v.abort_at) abort = 1;
        else begin
          rec_valid = 1;
          rec_data = (n == v.bad_idx) ? 7'b1100000 : good_rec(n);
          n++;
        end
      end
      tick();
      cyc++;
    end
    abort = 0; rec_valid = 0;
    tick();
    chk($sformatf("v%0d_timeout", idx), cyc < 80, 1);
    chk($sformatf("v%0d_nwr", idx), wr_total - w0, v.exp_nwr);
    chk($sformatf("v%0d_done", idx), done_total - d0, v.exp_done);
    chk($sformatf("v%0d_err", idx), err, v.exp_err);
    chk($sformatf("v%0d_ready", idx), rec_ready, 0);
    if (v.exp_nwr > 0) chk($sformatf("v%0d_last", idx), last_wr_addr, v.exp_last);
  endtask

  vec_t vecs[8];
  logic [5:0] wr_pat, done_pat, busy_pat;
  logic [4:0] addr_at[6];

  initial begin
    vecs[0] = '{5'd3,  6'd4,  -1, -1, 4,  5'd6,  1, 1'b0};
    vecs[1] = '{5'd30, 6'd4,  -1, -1, 4,  5'd1,  1, 1'b0};
    vecs[2] = '{5'd10, 6'd5,   1, -1, 4,  5'd14, 1, 1'b1};
    vecs[3] = '{5'd0,  6'd2,  -1, -1, 2,  5'd1,  1, 1'b0};
    vecs[4] = '{5'd7,  6'd0,  -1, -1, 0,  5'd0,  1, 1'b0};
    vecs[5] = '{5'd20, 6'd6,  -1,  2, 2,  5'd21, 0, 1'b0};
    vecs[6] = '{5'd0,  6'd32, -1, -1, 32, 5'd31, 1, 1'b0};
    vecs[7] = '{5'd31, 6'd1,  -1, -1, 1,  5'd31, 1, 1'b0};

    rst = 1;
    tick();
    chk_on = 1;
    tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 0;
    tick();

    // Exact timing: base 3, four legal records streamed back to back.
    load_start = 1; base_addr = 5'd3; page_cnt = 6'd4; rec_valid = 1; rec_data = 7'b0100011;
    for (int j = 0; j < 6; j++) begin
      sample();
      wr_pat[j] = wr_en; done_pat[j] = done; busy_pat[j] = busy; addr_at[j] = wr_addr;
      #1;
      load_start = 0;
    end
    rec_valid = 0;
    chk("seq_wr_pattern", wr_pat, 6'b011110);
    chk("seq_done_pattern", done_pat, 6'b010000);
    chk("seq_busy_pattern", busy_pat, 6'b011111);
    chk("seq_addr1", addr_at[1], 5'd3);
    chk("seq_addr2", addr_at[2], 5'd4);
    chk("seq_addr3", addr_at[3], 5'd5);
    chk("seq_addr_done", addr_at[4], 5'd6);
    tick();

    // Zero-length session.
    load_start = 1; base_addr = 5'd9; page_cnt = 6'd0;
    sample();
    chk("cnt0_busy", busy, 1);
    chk("cnt0_done", done, 1);
    chk("cnt0_wr_en", wr_en, 0);
    #1;
    load_start = 0;
    sample();
    chk("cnt0_busy_after", busy, 0);
    chk("cnt0_done_after", done, 0);
    #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset in the cycle after an acceptance.
    load_start = 1; base_addr = 5'd5; page_cnt = 6'd3;
    tick();
    load_start = 0; rec_valid = 1; rec_data = 7'b0010010;
    sample();
    chk("rstmid_wr_en", wr_en, 1);
    chk("rstmid_wr_addr", wr_addr, 5'd5);
    #1;
    rst = 1; rec_valid = 0;
    sample();
    chk("rstmid_wr_en_after", wr_en, 0);
    chk("rstmid_wr_addr_after", wr_addr, 0);
    chk("rstmid_wr_data_after", wr_data, 0);
    chk("rstmid_ready_after", rec_ready, 0);
    chk("rstmid_busy_after", busy, 0);
    chk("rstmid_done_after", done, 0);
    chk("rstmid_err_after", err, 0);
    #1;
    rst = 0;
    tick();

    // Randomized traffic, all cycles checked against the model.
    for (int i = 0; i < 4000; i++) begin
      load_start = ($urandom_range(0, 9) == 0);
      base_addr  = 5'($urandom);
      page_cnt   = 6'($urandom_range(0, 32));
      rec_valid  = ($urandom_range(0, 9) < 7);
      rec_data   = 7'($urandom);
      abort      = ($urandom_range(0, 49) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      tick();
    end
    load_start = 0; rec_valid = 0; abort = 0; rst = 0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
